// File: rtl/imem_loader_if.sv
// imem_loader_if: groups the host byte handshake, the instruction-memory
// write port and the fetch-hold/status lines of the loader.
//   start      : one-cycle re-arm pulse (host -> loader)
//   byte_valid : byte_data is valid (host -> loader)
//   byte_data  : stream byte (host -> loader)
//   byte_ready : loader accepts a byte this cycle (loader -> host)
//   wr_en      : one-cycle instruction memory write strobe
//   wr_addr    : word-aligned byte address of the written word
//   wr_data    : instruction word
//   cpu_hold   : holds the fetch stage while a load is not complete
//   done / err : load completed with good checksum / load rejected
interface imem_loader_if;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
  );

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream (LEN0 LEN1 | 4*N data bytes |
// CSUM) and writes little-endian 32-bit words into instruction memory,
// holding the fetch stage until a load completes with a matching checksum.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : imem_loader_if slave (byte handshake, write port, hold/status)
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_LEN0  = 3'd0,
    S_LEN1  = 3'd1,
    S_DATA  = 3'd2,
    S_CSUM  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  // Running frame checksum: XOR of every byte accepted so far.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    csum_step = acc ^ b;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] len_q;
  logic [15:0] idx_q;
  logic [1:0]  bcnt_q;
  logic [31:0] shift_q;
  logic [7:0]  xor_q;
  logic        byte_ready_q;
  logic        cpu_hold_q;
  logic        done_q;
  logic        err_q;
  logic        wr_en_q;
  logic [31:0] wr_addr_q;
  logic [31:0] wr_data_q;

  logic        accept_s;
  logic        terminal_s;
  logic [15:0] len_full_s;
  logic        last_word_s;
  logic [31:0] word_s;

  assign accept_s    = bus.byte_valid & byte_ready_q;
  assign terminal_s  = (state_q == S_DONE) || (state_q == S_ERROR);
  assign len_full_s  = {bus.byte_data, len_q[7:0]};
  assign last_word_s = (idx_q == (len_q - 16'd1));
  // Shift in from the top so the first byte of a word ends up in bits [7:0].
  assign word_s      = {bus.byte_data, shift_q[31:8]};

  // Next-state decode of the frame parser.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LEN0: begin
        if (accept_s) state_d = S_LEN1;
        else          state_d = state_q;
      end
      S_LEN1: begin
        if (!accept_s)                                     state_d = state_q;
        else if (len_full_s == 16'd0)                      state_d = S_CSUM;
        else if ({16'd0, len_full_s} > 32'(MAX_WORDS))     state_d = S_ERROR;
        else                                               state_d = S_DATA;
      end
      S_DATA: begin
        if (accept_s && (bcnt_q == 2'd3) && last_word_s) state_d = S_CSUM;
        else                                             state_d = state_q;
      end
      S_CSUM: begin
        if (!accept_s)                   state_d = state_q;
        else if (bus.byte_data == xor_q) state_d = S_DONE;
        else                             state_d = S_ERROR;
      end
      S_DONE, S_ERROR: begin
        if (bus.start) state_d = S_LEN0;
        else           state_d = state_q;
      end
      default: state_d = S_LEN0;
    endcase
  end

  // State, datapath and registered outputs; flags are decoded from state_d so
  // they change on the same edge as the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LEN0;
      len_q        <= 16'd0;
      idx_q        <= 16'd0;
      bcnt_q       <= 2'd0;
      shift_q      <= 32'd0;
      xor_q        <= 8'd0;
      byte_ready_q <= 1'b1;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 32'd0;
      wr_data_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      byte_ready_q <= (state_d != S_DONE) && (state_d != S_ERROR);
      cpu_hold_q   <= (state_d != S_DONE);
      done_q       <= (state_d == S_DONE);
      err_q        <= (state_d == S_ERROR);
      wr_en_q      <= 1'b0;

      if (accept_s) begin
        xor_q <= csum_step(xor_q, bus.byte_data);
        case (state_q)
          S_LEN0: len_q[7:0]  <= bus.byte_data;
          S_LEN1: len_q[15:8] <= bus.byte_data;
          S_DATA: begin
            shift_q <= word_s;
            bcnt_q  <= bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              wr_en_q   <= 1'b1;
              wr_data_q <= word_s;
              wr_addr_q <= BASE_ADDR + {14'd0, idx_q, 2'b00};
              idx_q     <= idx_q + 16'd1;
            end
          end
          default: ;
        endcase
      end

      // Re-arm from a terminal state: clear all per-frame bookkeeping.
      if (terminal_s && bus.start) begin
        len_q   <= 16'd0;
        idx_q   <= 16'd0;
        bcnt_q  <= 2'd0;
        shift_q <= 32'd0;
        xor_q   <= 8'd0;
      end
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.cpu_hold   = cpu_hold_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
module tb_imem_loader;
  logic clk;
  logic rst_n;
  imem_loader_if bus ();

  imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          double_strobe = 0;
  logic        prev_wen = 1'b0;

  logic [7:0] frame_ok  [11] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                                 8'h93, 8'h00, 8'h50, 8'h00, 8'hD2};
  logic [7:0] frame_one [7]  = '{8'h01, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00, 8'h62};
  int         gaps      [11] = '{0, 1, 3, 2, 1, 2, 3, 1, 2, 3, 1};

  // Write-port monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wa_q.push_back(bus.wr_addr);
      wd_q.push_back(bus.wr_data);
      if (prev_wen) double_strobe++;
    end
    prev_wen = (bus.wr_en === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    double_strobe = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents one byte after `gap` idle cycles; returns 1 ns after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    if (gap > 0) begin
      @(negedge clk);
      bus.byte_valid = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    bus.start = 1'b0;
    #12;
    vectors++; if (bus.byte_ready !== 1'b1) begin miscompares++; $display("FAIL reset_byte_ready got %b want 1", bus.byte_ready); end
    vectors++; if (bus.cpu_hold !== 1'b1) begin miscompares++; $display("FAIL reset_cpu_hold got %b want 1", bus.cpu_hold); end
    vectors++; if (bus.wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en got %b want 0", bus.wr_en); end
    vectors++; if (bus.wr_addr !== 32'h0) begin miscompares++; $display("FAIL reset_wr_addr got %h want 0", bus.wr_addr); end
    vectors++; if (bus.wr_data !== 32'h0) begin miscompares++; $display("FAIL reset_wr_data got %h want 0", bus.wr_data); end
    vectors++; if (bus.done !== 1'b0 || bus.err !== 1'b0) begin miscompares++; $display("FAIL reset_status got done=%b err=%b want 0 0", bus.done, bus.err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_two_word();
    clear_log();
    for (int i = 0; i < 10; i++) send_byte(frame_ok[i], 0);
    vectors++; if (bus.cpu_hold !== 1'b1 || bus.done !== 1'b0) begin miscompares++; $display("FAIL two_pre_csum got hold=%b done=%b want 1 0", bus.cpu_hold, bus.done); end
    send_byte(frame_ok[10], 0);
    vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL two_done_timing got %b want 1", bus.done); end
    idle(2);
    vectors++; if (wa_q.size() !== 2) begin miscompares++; $display("FAIL two_write_count got %0d want 2", wa_q.size()); end
    vectors++; if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'h0000_0013) begin miscompares++; $display("FAIL two_write0 got (%h,%h) want (0,00000013)", wa_q[0], wd_q[0]); end
    vectors++; if (wa_q[1] !== 32'h4 || wd_q[1] !== 32'h0050_0093) begin miscompares++; $display("FAIL two_write1 got (%h,%h) want (4,00500093)", wa_q[1], wd_q[1]); end
    vectors++; if (double_strobe !== 0) begin miscompares++; $display("FAIL two_strobe_width got %0d long strobes want 0", double_strobe); end
    vectors++; if (bus.done !== 1'b1 || bus.cpu_hold !== 1'b0 || bus.err !== 1'b0 || bus.byte_ready !== 1'b0) begin miscompares++; $display("FAIL two_final got done=%b hold=%b err=%b rdy=%b want 1 0 0 0", bus.done, bus.cpu_hold, bus.err, bus.byte_ready); end
  endtask

  task automatic test_gaps();
    apply_reset();
    clear_log();
    for (int i = 0; i < 11; i++) send_byte(frame_ok[i], gaps[i]);
    idle(2);
    vectors++; if (wa_q.size() !== 2) begin miscompares++; $display("FAIL gap_write_count got %0d want 2", wa_q.size()); end
    vectors++; if (wd_q[0] !== 32'h0000_0013 || wd_q[1] !== 32'h0050_0093 || wa_q[1] !== 32'h4) begin miscompares++; $display("FAIL gap_writes got %h %h @%h want 00000013 00500093 @4", wd_q[0], wd_q[1], wa_q[1]); end
    vectors++; if (bus.done !== 1'b1 || bus.cpu_hold !== 1'b0 || bus.err !== 1'b0) begin miscompares++; $display("FAIL gap_final got done=%b hold=%b err=%b want 1 0 0", bus.done, bus.cpu_hold, bus.err); end
  endtask

  task automatic test_zero_len();
    apply_reset();
    clear_log();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    idle(2);
    vectors++; if (wa_q.size() !== 0) begin miscompares++; $display("FAIL zero_writes got %0d want 0", wa_q.size()); end
    vectors++; if (bus.done !== 1'b1 || bus.err !== 1'b0) begin miscompares++; $display("FAIL zero_status got done=%b err=%b want 1 0", bus.done, bus.err); end
  endtask

  task automatic test_oversize();
    apply_reset();
    clear_log();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    vectors++; if (bus.err !== 1'b1 || bus.byte_ready !== 1'b0 || bus.cpu_hold !== 1'b1 || bus.done !== 1'b0) begin miscompares++; $display("FAIL over_state got err=%b rdy=%b hold=%b done=%b want 1 0 1 0", bus.err, bus.byte_ready, bus.cpu_hold, bus.done); end
    // Out-of-frame bytes in ERROR must be ignored.
    bus.byte_data = 8'h13;
    repeat (8) @(negedge clk);
    idle(1);
    vectors++; if (wa_q.size() !== 0) begin miscompares++; $display("FAIL over_writes got %0d want 0", wa_q.size()); end
    vectors++; if (bus.err !== 1'b1 || bus.byte_ready !== 1'b0) begin miscompares++; $display("FAIL over_sticky got err=%b rdy=%b want 1 0", bus.err, bus.byte_ready); end
  endtask

  task automatic test_bad_csum();
    apply_reset();
    clear_log();
    for (int i = 0; i < 10; i++) send_byte(frame_ok[i], 0);
    send_byte(8'hD3, 0);
    vectors++; if (bus.err !== 1'b1 || bus.done !== 1'b0 || bus.cpu_hold !== 1'b1) begin miscompares++; $display("FAIL bad_status got err=%b done=%b hold=%b want 1 0 1", bus.err, bus.done, bus.cpu_hold); end
    idle(2);
    vectors++; if (wa_q.size() !== 2 || wd_q[1] !== 32'h0050_0093) begin miscompares++; $display("FAIL bad_writes got %0d writes last %h want 2 00500093", wa_q.size(), wd_q[1]); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    clear_log();
    for (int i = 0; i < 6; i++) send_byte(frame_ok[i], 0);
    vectors++; if (bus.wr_en !== 1'b1) begin miscompares++; $display("FAIL mid_pending_write got %b want 1", bus.wr_en); end
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (bus.wr_en !== 1'b0 || bus.wr_addr !== 32'h0 || bus.wr_data !== 32'h0) begin miscompares++; $display("FAIL mid_async_clear got en=%b addr=%h data=%h want 0 0 0", bus.wr_en, bus.wr_addr, bus.wr_data); end
    vectors++; if (bus.byte_ready !== 1'b1 || bus.cpu_hold !== 1'b1 || bus.done !== 1'b0 || bus.err !== 1'b0) begin miscompares++; $display("FAIL mid_async_flags got rdy=%b hold=%b done=%b err=%b want 1 1 0 0", bus.byte_ready, bus.cpu_hold, bus.done, bus.err); end
    bus.byte_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    for (int i = 0; i < 11; i++) send_byte(frame_ok[i], 0);
    idle(2);
    vectors++; if (wa_q.size() !== 2 || wa_q[0] !== 32'h0 || wd_q[0] !== 32'h0000_0013) begin miscompares++; $display("FAIL mid_reload got %0d writes first (%h,%h) want 2 (0,00000013)", wa_q.size(), wa_q[0], wd_q[0]); end
    vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL mid_reload_done got %b want 1", bus.done); end
  endtask

  task automatic test_restart();
    clear_log();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    vectors++; if (bus.done !== 1'b0 || bus.cpu_hold !== 1'b1 || bus.byte_ready !== 1'b1) begin miscompares++; $display("FAIL restart_rearm got done=%b hold=%b rdy=%b want 0 1 1", bus.done, bus.cpu_hold, bus.byte_ready); end
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(frame_one[i], 0);
    vectors++; if (bus.cpu_hold !== 1'b1) begin miscompares++; $display("FAIL restart_hold got %b want 1", bus.cpu_hold); end
    send_byte(frame_one[6], 0);
    vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL restart_done got %b want 1", bus.done); end
    idle(2);
    vectors++; if (wa_q.size() !== 1 || wa_q[0] !== 32'h0 || wd_q[0] !== 32'h0010_0073) begin miscompares++; $display("FAIL restart_write got %0d writes (%h,%h) want 1 (0,00100073)", wa_q.size(), wa_q[0], wd_q[0]); end
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_gaps();
    test_zero_len();
    test_oversize();
    test_bad_csum();
    test_reset_mid();
    test_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
